mem_bus_arbiter: RTL and testbench

//  Shares the single byte-wide RAM/IO bus between instruction fetch (ICache miss path) and

---
 rtl/mem_bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: byte-serial RAM/IO bus shared by fetch and load/store.
// Define MEM_ARB_STARVE_EN to bound fetch starvation under LS traffic.
module mem_bus_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        flush,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);
   typedef enum logic [2:0] {
      IDLE, IF_RD, LS_RD, LS_WR, LS_WAIT_IO
   } state_t;

   state_t      state;
   logic [31:0] base, wdata;
   logic [2:0]  n, s, rw, ls_n;
   logic [1:0]  lane;
   logic        pv, frz, io, wr_q;
   logic        ls_io, pick_ls, pick_if, grant_ok;

   assign mem_wr   = wr_q & rdy_in;
   assign ls_io    = (ls_addr[17:16] == 2'b11);
   assign lane     = s[1:0] - 2'd1;
   // pv: mem_din currently holds byte s-1; rewind to it after a freeze
   assign rw       = pv ? s - 3'd1 : s;
   assign grant_ok = rdy_in && state == IDLE && !if_done && !ls_done;

   always_comb begin
      ls_n = 3'd4;
      unique case (ls_size)
         2'd0:    ls_n = 3'd1;
         2'd1:    ls_n = 3'd2;
         default: ls_n = 3'd4;
      endcase
   end

`ifdef MEM_ARB_STARVE_EN
   logic [CNT_W-1:0] starve_cnt;
   logic             force_if;

   assign force_if = if_req && (starve_cnt == CNT_W'(STARVE_MAX));
   assign pick_ls  = ls_req && !force_if;

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         starve_cnt <= '0;
      end else if (grant_ok) begin
         if (pick_ls && if_req && !force_if)
            starve_cnt <= starve_cnt + 1'b1;
         else if (pick_if)
            starve_cnt <= '0;
      end
   end
`else
   assign pick_ls = ls_req;
`endif

   assign pick_if = if_req && !flush && !pick_ls;

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state    <= IDLE;
         base     <= '0;
         wdata    <= '0;
         n        <= '0;
         s        <= '0;
         pv       <= 1'b0;
         frz      <= 1'b0;
         io       <= 1'b0;
         wr_q     <= 1'b0;
         if_done  <= 1'b0;
         ls_done  <= 1'b0;
         if_data  <= '0;
         ls_rdata <= '0;
         mem_a    <= '0;
         mem_dout <= '0;
      end else begin
         frz <= !rdy_in;
         if (rdy_in) begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            unique case (state)
               IDLE: begin
                  if (grant_ok && pick_ls) begin
                     base  <= ls_addr;
                     wdata <= ls_wdata;
                     n     <= ls_n;
                     io    <= ls_io;
                     pv    <= 1'b0;
                     if (!ls_we) begin
                        state    <= LS_RD;
                        mem_a    <= ls_addr;
                        ls_rdata <= '0;
                        s        <= 3'd0;
                     end else if (ls_io && io_buffer_full) begin
                        state <= LS_WAIT_IO;
                        mem_a <= '0;
                        s     <= 3'd0;
                     end else begin
                        state    <= LS_WR;
                        mem_a    <= ls_addr;
                        mem_dout <= ls_wdata[7:0];
                        wr_q     <= 1'b1;
                        s        <= 3'd1;
                     end
                  end else if (grant_ok && pick_if) begin
                     state   <= IF_RD;
                     base    <= if_addr;
                     mem_a   <= if_addr;
                     n       <= 3'd4;
                     s       <= 3'd0;
                     pv      <= 1'b0;
                     io      <= 1'b0;
                     if_data <= '0;
                  end
               end
               IF_RD, LS_RD: begin
                  if (state == IF_RD && flush) begin
                     state <= IDLE;
                     wr_q  <= 1'b0;
                  end else if (frz) begin
                     mem_a <= base + {29'b0, rw};
                     s     <= rw;
                     pv    <= 1'b0;
                  end else begin
                     if (pv && state == IF_RD)
                        if_data[{lane, 3'b000} +: 8] <= mem_din;
                     if (pv && state == LS_RD)
                        ls_rdata[{lane, 3'b000} +: 8] <= mem_din;
                     if (pv && s == n) begin
                        state   <= IDLE;
                        if_done <= (state == IF_RD);
                        ls_done <= (state == LS_RD);
                     end else begin
                        if (s + 3'd1 < n)
                           mem_a <= base + {29'b0, s + 3'd1};
                        s  <= s + 3'd1;
                        pv <= 1'b1;
                     end
                  end
               end
               LS_WR: begin
                  if (s == n) begin
                     state   <= IDLE;
                     wr_q    <= 1'b0;
                     ls_done <= 1'b1;
                  end else if (io && io_buffer_full) begin
                     state <= LS_WAIT_IO;
                     wr_q  <= 1'b0;
                     mem_a <= '0;
                  end else begin
                     mem_a    <= base + {29'b0, s};
                     mem_dout <= wdata[{s[1:0], 3'b000} +: 8];
                     s        <= s + 3'd1;
                  end
               end
               LS_WAIT_IO: begin
                  if (!io_buffer_full) begin
                     state    <= LS_WR;
                     wr_q     <= 1'b1;
                     mem_a    <= base + {29'b0, s};
                     mem_dout <= wdata[{s[1:0], 3'b000} +: 8];
                     s        <= s + 3'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench with a byte RAM model behind the bus.
// Build with +define+MEM_ARB_STARVE_EN to exercise the starvation bound.
module tb_mem_bus_arbiter;
   logic        clk = 1'b0;
   logic        rst_n, rdy, flush, if_req, ls_req, ls_we, io_full;
   logic [31:0] if_addr, ls_addr, ls_wdata, if_data, ls_rdata, mem_a;
   logic [1:0]  ls_size;
   logic        if_done, ls_done, mem_wr;
   logic [7:0]  mem_din, mem_dout;
   logic [7:0]  ram [0:65535];
   int          wr_cnt = 0;
   logic [7:0]  io_byte = 8'h00;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter dut (
      .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
      .if_data(if_data), .ls_req(ls_req), .ls_we(ls_we),
      .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_done(ls_done), .ls_rdata(ls_rdata), .mem_din(mem_din),
      .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_full)
   );

   always @(posedge clk) begin
      if (mem_wr) begin
         wr_cnt <= wr_cnt + 1;
         if (mem_a[17:16] == 2'b11) io_byte <= mem_dout;
      end
      mem_din <= ram[mem_a[15:0]];
   end

   task automatic test_reset();
      logic seen;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++; if ({if_done, ls_done, mem_wr} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {if_done, ls_done, mem_wr}); end
      tests++; if (if_data !== 32'h0 || ls_rdata !== 32'h0) begin fails++; $display("FAIL reset_data: got %h/%h want 0", if_data, ls_rdata); end
      tests++; if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin fails++; $display("FAIL reset_bus: got %h/%h want 0", mem_a, mem_dout); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); if_req = 1'b1; if_addr = 32'h100;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      tests++; if (mem_a !== 32'h0) begin fails++; $display("FAIL reset_mid_a: got %h want 0", mem_a); end
      @(negedge clk); rst_n = 1'b1; if_req = 1'b0;
      seen = 1'b0;
      repeat (8) begin @(posedge clk); #1; if (if_done) seen = 1'b1; end
      tests++; if (seen !== 1'b0) begin fails++; $display("FAIL reset_mid_done: got %b want 0", seen); end
   endtask

   task automatic test_fetch();
      logic [31:0] exp;
      @(negedge clk); if_req = 1'b1; if_addr = 32'h100;
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         #1; exp = 32'h100 + k;
         tests++; if (mem_a !== exp || mem_wr !== 1'b0) begin fails++; $display("FAIL fetch_addr%0d: got %h wr %b want %h wr 0", k, mem_a, mem_wr, exp); end
         @(posedge clk);
      end
      #1;
      tests++; if (if_done !== 1'b0) begin fails++; $display("FAIL fetch_early: got %b want 0", if_done); end
      @(posedge clk); #1;
      tests++; if (if_done !== 1'b1 || if_data !== 32'h00100513) begin fails++; $display("FAIL fetch_done: got %b %h want 1 00100513", if_done, if_data); end
      @(negedge clk); if_req = 1'b0;
      @(posedge clk); #1;
      tests++; if (if_done !== 1'b0) begin fails++; $display("FAIL fetch_pulse: got %b want 0", if_done); end
   endtask

   task automatic test_store();
      logic [31:0] d;
      logic [40:0] exp;
      d = 32'hDEADBEEF;
      @(negedge clk);
      ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h2000; ls_wdata = d;
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         #1; exp = {1'b1, 32'h2000 + k, d[8*k +: 8]};
         tests++; if ({mem_wr, mem_a, mem_dout} !== exp) begin fails++; $display("FAIL store_byte%0d: got %h want %h", k, {mem_wr, mem_a, mem_dout}, exp); end
         @(posedge clk);
      end
      #1;
      tests++; if (ls_done !== 1'b1 || mem_wr !== 1'b0) begin fails++; $display("FAIL store_done: got %b wr %b want 1 wr 0", ls_done, mem_wr); end
      @(negedge clk); ls_req = 1'b0; ls_we = 1'b0;
   endtask

   task automatic test_load_half();
      @(negedge clk);
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd1; ls_addr = 32'h1FFE;
      @(posedge clk); #1;
      tests++; if (mem_a !== 32'h1FFE) begin fails++; $display("FAIL half_a0: got %h want 1ffe", mem_a); end
      @(posedge clk); #1;
      tests++; if (mem_a !== 32'h1FFF) begin fails++; $display("FAIL half_a1: got %h want 1fff", mem_a); end
      @(posedge clk); #1;
      tests++; if (ls_done !== 1'b0) begin fails++; $display("FAIL half_early: got %b want 0", ls_done); end
      @(posedge clk); #1;
      tests++; if (ls_done !== 1'b1 || ls_rdata !== 32'h0000FF80) begin fails++; $display("FAIL half_done: got %b %h want 1 0000ff80", ls_done, ls_rdata); end
      @(negedge clk); ls_req = 1'b0;
   endtask

   task automatic test_io_store();
      int w0;
      w0 = wr_cnt;
      @(negedge clk);
      io_full = 1'b1; ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0;
      ls_addr = 32'h30000; ls_wdata = 32'h41;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         tests++; if (mem_wr !== 1'b0 || mem_a !== 32'h0) begin fails++; $display("FAIL io_hold%0d: got wr %b a %h want 0 0", i, mem_wr, mem_a); end
      end
      @(negedge clk); io_full = 1'b0;
      @(posedge clk); #1;
      tests++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h30000, 8'h41}) begin fails++; $display("FAIL io_write: got %h want 1_00030000_41", {mem_wr, mem_a, mem_dout}); end
      @(posedge clk); #1;
      tests++; if (ls_done !== 1'b1 || mem_wr !== 1'b0) begin fails++; $display("FAIL io_done: got %b wr %b want 1 0", ls_done, mem_wr); end
      tests++; if (wr_cnt - w0 !== 1 || io_byte !== 8'h41) begin fails++; $display("FAIL io_count: got %0d %h want 1 41", wr_cnt - w0, io_byte); end
      @(negedge clk); ls_req = 1'b0; ls_we = 1'b0;
   endtask

   task automatic test_flush();
      logic seen, got;
      @(negedge clk); if_req = 1'b1; if_addr = 32'h100;
      repeat (3) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h1FFF;
      seen = if_done;
      @(posedge clk); #1;
      seen = seen | if_done;
      tests++; if (mem_a !== 32'h1FFF || mem_wr !== 1'b0) begin fails++; $display("FAIL flush_ls_grant: got %h want 1fff", mem_a); end
      repeat (2) @(posedge clk);
      #1;
      seen = seen | if_done;
      tests++; if (ls_done !== 1'b1 || ls_rdata !== 32'h000000FF) begin fails++; $display("FAIL flush_ls_done: got %b %h want 1 000000ff", ls_done, ls_rdata); end
      tests++; if (seen !== 1'b0) begin fails++; $display("FAIL flush_no_if_done: got %b want 0", seen); end
      @(negedge clk); ls_req = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 15 && !got; i++) begin @(posedge clk); #1; if (if_done) got = 1'b1; end
      tests++; if (got !== 1'b1 || if_data !== 32'h00100513) begin fails++; $display("FAIL flush_refetch: got %b %h want 1 00100513", got, if_data); end
      @(negedge clk); if_req = 1'b0;
   endtask

   task automatic test_freeze();
      logic got;
      int   w0;
      @(negedge clk); if_req = 1'b1; if_addr = 32'h100;
      repeat (3) @(posedge clk);
      @(negedge clk); rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (mem_a !== 32'h102) begin fails++; $display("FAIL frz_hold_a: got %h want 102", mem_a); end
      @(negedge clk); rdy = 1'b1;
      @(posedge clk); #1;
      tests++; if (mem_a !== 32'h101) begin fails++; $display("FAIL frz_reissue: got %h want 101", mem_a); end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin @(posedge clk); #1; if (if_done) got = 1'b1; end
      tests++; if (got !== 1'b1 || if_data !== 32'h00100513) begin fails++; $display("FAIL frz_fetch: got %b %h want 1 00100513", got, if_data); end
      @(negedge clk); if_req = 1'b0;
      @(negedge clk);
      w0 = wr_cnt;
      ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h2000; ls_wdata = 32'h11223344;
      @(posedge clk);
      @(negedge clk); rdy = 1'b0;
      #1;
      tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL frz_wr_gate: got %b want 0", mem_wr); end
      repeat (2) @(posedge clk);
      @(negedge clk); rdy = 1'b1;
      #1;
      tests++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h2000, 8'h44}) begin fails++; $display("FAIL frz_wr_resume: got %h want 1_00002000_44", {mem_wr, mem_a, mem_dout}); end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin @(posedge clk); #1; if (ls_done) got = 1'b1; end
      tests++; if (got !== 1'b1 || wr_cnt - w0 !== 4) begin fails++; $display("FAIL frz_store: got %b writes %0d want 1 4", got, wr_cnt - w0); end
      @(negedge clk); ls_req = 1'b0; ls_we = 1'b0;
   endtask

   task automatic test_wrap();
      logic [31:0] exp;
      @(negedge clk);
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'hFFFF_FFFE;
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         #1; exp = 32'hFFFF_FFFE + k;
         tests++; if (mem_a !== exp) begin fails++; $display("FAIL wrap_addr%0d: got %h want %h", k, mem_a, exp); end
         @(posedge clk);
      end
      @(posedge clk); #1;
      tests++; if (ls_done !== 1'b1 || ls_rdata !== 32'h04030201) begin fails++; $display("FAIL wrap_done: got %b %h want 1 04030201", ls_done, ls_rdata); end
      @(negedge clk); ls_req = 1'b0;
   endtask

   task automatic test_starve();
      logic [4:0] seq, exp;
      int         ev;
      @(negedge clk);
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h1FFE;
      if_req = 1'b1; if_addr = 32'h100;
      seq = '0; ev = 0;
      for (int i = 0; i < 80 && ev < 5; i++) begin
         @(posedge clk); #1;
         if (ls_done) ev++;
         if (if_done) begin seq[ev] = 1'b1; ev++; end
      end
`ifdef MEM_ARB_STARVE_EN
      exp = 5'b10000;
      tests++; if (dut.starve_cnt !== 3'd0) begin fails++; $display("FAIL starve_cnt: got %0d want 0", dut.starve_cnt); end
`else
      exp = 5'b00000;
`endif
      tests++; if (ev !== 5 || seq !== exp) begin fails++; $display("FAIL starve_order: got %0d ev seq %b want 5 %b", ev, seq, exp); end
      @(negedge clk); ls_req = 1'b0; if_req = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
      if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0;
      if_addr = '0; ls_addr = '0; ls_wdata = '0;
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05;
      ram[16'h0102] = 8'h10; ram[16'h0103] = 8'h00;
      ram[16'h1FFE] = 8'h80; ram[16'h1FFF] = 8'hFF;
      ram[16'hFFFE] = 8'h01; ram[16'hFFFF] = 8'h02;
      ram[16'h0000] = 8'h03; ram[16'h0001] = 8'h04;
      test_reset();
      test_fetch();
      test_store();
      test_load_half();
      test_io_store();
      test_flush();
      test_freeze();
      test_wrap();
      test_starve();
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
